ar_burst_gen: RTL and testbench
===============================

Name: ar_burst_gen

Overview:
Parametrised successor to the processor's address register. It loads from one of NSRC source buses, selected per cycle, and holds the value otherwise. It adds an autonomous burst mode: after a load it steps the address by a programmable stride, up or down, for Len cycles. A Start/Busy/Done handshake lets the control unit issue block memory accesses without re-driving the bus every cycle.

Parameters:
WIDTH, 8, address/data width.
NSRC, 2, number of load sources (2..2^SELW).
SELW, 1, width of source select.
CNTW, 8, width of burst length counter.

Ports:
Clk  input  1  clock, rising edge.
nRst  input  1  synchronous reset, active low.
WEN  input  1  load enable.
Sel  input  SELW  source select, index into Din.
Din  input  NSRC*WIDTH  flattened sources; source i = Din[i*WIDTH +: WIDTH].
Start  input  1  begin burst (sampled in IDLE only).
Len  input  CNTW  number of steps in burst.
Stride  input  WIDTH  unsigned step size.
Dir  input  1  0 = increment, 1 = decrement.
Hold  input  1  freeze stepping during RUN.
dout  output  WIDTH  current address.
Busy  output  1  high while in RUN.
Done  output  1  one-cycle pulse at burst end.
Wrap  output  1  one-cycle pulse when a step wrapped modulo 2^WIDTH.

Behaviour:
- All state changes on the rising Clk edge.
- nRst=0 at an edge: dout=0, Busy=0, Done=0, Wrap=0, remaining count=0, state=IDLE.
- nRst has priority over every other input, including mid-burst: a burst aborts with no Done.
- States: IDLE, RUN, DONE. Busy and Done are registered outputs: Busy = (state==RUN), Done = (state==DONE).
- IDLE, load:
  - WEN=1 and Sel<NSRC: dout <= source[Sel]; visible the cycle after the edge.
  - WEN=1 and Sel>=NSRC: dout holds.
  - WEN=0: dout holds.
- IDLE, Start=1 and Len!=0:
  - Latch Len into the remaining counter; latch Stride and Dir; go to RUN.
  - If WEN=1 in the same cycle, the load also happens. The burst starts from the loaded value.
- IDLE, Start=1 and Len==0: go directly to DONE (Done pulse, no step).
- RUN, Hold=0, at each edge:
  - Dir=0: dout <= (dout + Stride) mod 2^WIDTH.
  - Dir=1: dout <= (dout - Stride) mod 2^WIDTH.
  - remaining decrements by 1.
  - Wrap <= carry-out of the add (Dir=0) or borrow-out of the subtract (Dir=1); otherwise Wrap <= 0.
  - The step that takes remaining from 1 to 0 also moves the state to DONE.
- RUN, Hold=1: dout, remaining and state unchanged; Wrap <= 0.
- RUN ignores WEN, Start, Len, Stride and Dir. Changing the inputs mid-burst has no effect.
- DONE: lasts exactly one cycle, then IDLE. WEN and Start are ignored in DONE. dout holds the final address.
- Timing for Start sampled at edge t with Len=L and no Hold:
  - Busy=1 after edges t .. t+L-1.
  - dout steps at edges t+1 .. t+L.
  - Done=1 after edge t+L.
  - IDLE again after edge t+L+1.
  - Each Hold cycle extends this schedule by one cycle.
- Stride=0 is legal: dout is unchanged and Busy/Done timing is the same.
- Wrap is never asserted outside RUN steps.

Test Plan:
1. Reset: drive nRst=0 for one edge after random activity -> dout=0x00, Busy=0, Done=0, Wrap=0.
2. Load with WIDTH=8, NSRC=2:
   - Din src0=0x12, src1=0x34; WEN=1, Sel=0 -> dout=0x12 next cycle.
   - Sel=1 -> dout=0x34.
   - WEN=0 with sources changed -> dout stays 0x34.
3. Up burst: dout=0x10; Start=1, Len=4, Stride=2, Dir=0 -> dout 0x12, 0x14, 0x16, 0x18 on consecutive cycles. Busy high 4 cycles, Done pulses once, dout stays 0x18, state returns to IDLE.
4. Wrap:
   - dout=0xFE, Len=3, Stride=1, Dir=0 -> 0xFF, 0x00 (Wrap=1 only on this cycle), 0x01.
   - dout=0x01, Len=1, Stride=2, Dir=1 -> 0xFF with Wrap=1.
5. Hold and ignored inputs: burst Len=3, Stride=1 from 0x20; Hold=1 for 2 cycles after the first step; WEN=1 with src0=0x55 during RUN -> sequence 0x21, 0x21, 0x21, 0x22, 0x23. Busy high 5 cycles, 0x55 never appears.
6. Edge cases:
   - Start with Len=0 -> Done pulse, Busy stays 0, dout unchanged.
   - WEN and Start in the same cycle with src0=0x40, Len=1, Stride=1 -> dout 0x40 then 0x41.
   - nRst=0 mid-burst -> dout=0, Busy=0, no Done pulse.

Source files
------------

// File: rtl/ar_burst_gen.sv
// ar_burst_gen: address register with multi-source load and an autonomous
// stride burst (up/down) under a Start/Busy/Done handshake.
module ar_burst_gen #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 2,
  parameter int SELW  = 1,
  parameter int CNTW  = 8
) (
  input  logic                    Clk,
  input  logic                    nRst,
  input  logic                    WEN,
  input  logic [SELW-1:0]         Sel,
  input  logic [NSRC*WIDTH-1:0]   Din,
  input  logic                    Start,
  input  logic [CNTW-1:0]         Len,
  input  logic [WIDTH-1:0]        Stride,
  input  logic                    Dir,
  input  logic                    Hold,
  output logic [WIDTH-1:0]        dout,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [WIDTH-1:0]  stride_q, stride_d;
  logic              dir_q, dir_d;
  logic [CNTW-1:0]   rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;

  logic [WIDTH-1:0]  src_sel;
  logic              src_ok;
  logic [WIDTH:0]    step_res;

  // One address step; the extra MSB carries the carry-out (up) or borrow-out (down).
  function automatic logic [WIDTH:0] step_addr(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] s,
                                               input logic             down);
    logic [WIDTH:0] ea;
    logic [WIDTH:0] es;
    ea = {1'b0, a};
    es = {1'b0, s};
    if (down) begin
      return ea - es;
    end
    return ea + es;
  endfunction

  assign step_res = step_addr(dout_q, stride_q, dir_q);

  // Source mux: an out-of-range select yields src_ok=0 so the register holds.
  always_comb begin
    src_sel = '0;
    src_ok  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (Sel == SELW'(i)) begin
        src_sel = Din[i*WIDTH +: WIDTH];
        src_ok  = 1'b1;
      end
    end
  end

  // Next-state logic: loads and burst launch in IDLE, stepping in RUN, one-cycle DONE.
  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    stride_d = stride_q;
    dir_d    = dir_q;
    rem_d    = rem_q;
    wrap_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (WEN && src_ok) begin
          dout_d = src_sel;
        end
        if (Start) begin
          if (Len != '0) begin
            // Stride and direction are captured so mid-burst input changes are ignored.
            rem_d    = Len;
            stride_d = Stride;
            dir_d    = Dir;
            state_d  = S_RUN;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!Hold) begin
          dout_d = step_res[WIDTH-1:0];
          wrap_d = step_res[WIDTH];
          rem_d  = rem_q - CNTW'(1);
          if (rem_q == CNTW'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset wins over everything, aborting any burst.
  always_ff @(posedge Clk) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      dout_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      stride_q <= stride_d;
      dir_q    <= dir_d;
    end
  end

  assign dout = dout_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_ar_burst_gen.sv
// Directed table-driven bench for ar_burst_gen (WIDTH=8, NSRC=2).
module tb_ar_burst_gen;

  logic        Clk;
  logic        nRst;
  logic        WEN;
  logic [0:0]  Sel;
  logic [15:0] Din;
  logic        Start;
  logic [7:0]  Len;
  logic [7:0]  Stride;
  logic        Dir;
  logic        Hold;
  logic [7:0]  dout;
  logic        Busy;
  logic        Done;
  logic        Wrap;

  int checks = 0;
  int errors = 0;

  ar_burst_gen #(.WIDTH(8), .NSRC(2), .SELW(1), .CNTW(8)) dut (
    .Clk(Clk), .nRst(nRst), .WEN(WEN), .Sel(Sel), .Din(Din),
    .Start(Start), .Len(Len), .Stride(Stride), .Dir(Dir), .Hold(Hold),
    .dout(dout), .Busy(Busy), .Done(Done), .Wrap(Wrap)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       wen;
    logic       sel;
    logic [7:0] s0;
    logic [7:0] s1;
    logic       start;
    logic [7:0] len;
    logic [7:0] stride;
    logic       dir;
    logic       hold;
    logic [7:0] e_dout;
    logic       e_busy;
    logic       e_done;
    logic       e_wrap;
  } vec_t;

  vec_t vq[$];

  task automatic v(input string n, input logic r, input logic w, input logic sl,
                   input logic [7:0] a, input logic [7:0] b, input logic st,
                   input logic [7:0] ln, input logic [7:0] sd, input logic d,
                   input logic h, input logic [7:0] ed, input logic eb,
                   input logic edn, input logic ew);
    vec_t x;
    x.name = n; x.rst_n = r; x.wen = w; x.sel = sl; x.s0 = a; x.s1 = b;
    x.start = st; x.len = ln; x.stride = sd; x.dir = d; x.hold = h;
    x.e_dout = ed; x.e_busy = eb; x.e_done = edn; x.e_wrap = ew;
    vq.push_back(x);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  initial begin
    int busy_cnt;
    int edges;
    bit done_seen;

    nRst = 1'b0; WEN = 1'b0; Sel = '0; Din = '0; Start = 1'b0;
    Len = '0; Stride = '0; Dir = 1'b0; Hold = 1'b0;

    //   name          rst wen sel s0     s1     st len    str    dir hld  dout  bsy dn wr
    v("reset0",        0,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h00, 0, 0, 0);
    v("activity",      1,  1,  1,  8'h00, 8'hAB, 1, 8'd3,  8'd1,  0,  0,  8'hAB, 1, 0, 0);
    v("reset_after",   0,  1,  1,  8'h00, 8'hCD, 1, 8'd3,  8'd1,  0,  0,  8'h00, 0, 0, 0);
    v("load_src0",     1,  1,  0,  8'h12, 8'h34, 0, 8'd0,  8'd0,  0,  0,  8'h12, 0, 0, 0);
    v("load_src1",     1,  1,  1,  8'h12, 8'h34, 0, 8'd0,  8'd0,  0,  0,  8'h34, 0, 0, 0);
    v("no_wen_hold",   1,  0,  0,  8'h77, 8'h88, 0, 8'd0,  8'd0,  0,  0,  8'h34, 0, 0, 0);
    // up burst from 0x10, stride 2, four steps; mid-burst input changes ignored
    v("up_load",       1,  1,  0,  8'h10, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h10, 0, 0, 0);
    v("up_start",      1,  0,  0,  8'h00, 8'h00, 1, 8'd4,  8'd2,  0,  0,  8'h10, 1, 0, 0);
    v("up_s1",         1,  0,  0,  8'h00, 8'h00, 1, 8'd9,  8'd7,  1,  0,  8'h12, 1, 0, 0);
    v("up_s2",         1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h14, 1, 0, 0);
    v("up_s3",         1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h16, 1, 0, 0);
    v("up_s4_done",    1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h18, 0, 1, 0);
    v("up_idle",       1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h18, 0, 0, 0);
    // carry wrap 0xFE -> 0xFF -> 0x00 -> 0x01
    v("wu_load",       1,  1,  0,  8'hFE, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'hFE, 0, 0, 0);
    v("wu_start",      1,  0,  0,  8'h00, 8'h00, 1, 8'd3,  8'd1,  0,  0,  8'hFE, 1, 0, 0);
    v("wu_s1",         1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'hFF, 1, 0, 0);
    v("wu_s2_wrap",    1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h00, 1, 0, 1);
    v("wu_s3_done",    1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h01, 0, 1, 0);
    v("wu_idle",       1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h01, 0, 0, 0);
    // borrow wrap 0x01 - 2 -> 0xFF
    v("wd_start",      1,  0,  0,  8'h00, 8'h00, 1, 8'd1,  8'd2,  1,  0,  8'h01, 1, 0, 0);
    v("wd_s1_wrap",    1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'hFF, 0, 1, 1);
    v("wd_idle",       1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'hFF, 0, 0, 0);
    // hold for two cycles, WEN with 0x55 during RUN and DONE must be ignored
    v("h_load",        1,  1,  0,  8'h20, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h20, 0, 0, 0);
    v("h_start",       1,  0,  0,  8'h00, 8'h00, 1, 8'd3,  8'd1,  0,  0,  8'h20, 1, 0, 0);
    v("h_s1",          1,  1,  0,  8'h55, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h21, 1, 0, 0);
    v("h_hold1",       1,  1,  0,  8'h55, 8'h00, 0, 8'd0,  8'd0,  0,  1,  8'h21, 1, 0, 0);
    v("h_hold2",       1,  1,  0,  8'h55, 8'h00, 1, 8'd2,  8'd5,  1,  1,  8'h21, 1, 0, 0);
    v("h_s2",          1,  1,  0,  8'h55, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h22, 1, 0, 0);
    v("h_s3_done",     1,  1,  0,  8'h55, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h23, 0, 1, 0);
    v("h_done_ign",    1,  1,  0,  8'h55, 8'h00, 1, 8'd2,  8'd1,  0,  0,  8'h23, 0, 0, 0);
    // Len=0 goes straight to a Done pulse
    v("len0_start",    1,  0,  0,  8'h00, 8'h00, 1, 8'd0,  8'd1,  0,  0,  8'h23, 0, 1, 0);
    v("len0_idle",     1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h23, 0, 0, 0);
    // load and start in the same cycle
    v("ls_start",      1,  1,  0,  8'h40, 8'h00, 1, 8'd1,  8'd1,  0,  0,  8'h40, 1, 0, 0);
    v("ls_s1_done",    1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h41, 0, 1, 0);
    v("ls_idle",       1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h41, 0, 0, 0);
    // reset in the middle of a burst: no Done afterwards
    v("rb_start",      1,  0,  0,  8'h00, 8'h00, 1, 8'd5,  8'd1,  0,  0,  8'h41, 1, 0, 0);
    v("rb_s1",         1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h42, 1, 0, 0);
    v("rb_reset",      0,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h00, 0, 0, 0);
    v("rb_after1",     1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h00, 0, 0, 0);
    v("rb_after2",     1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h00, 0, 0, 0);
    // stride 0 keeps dout, normal timing
    v("z_start",       1,  0,  0,  8'h00, 8'h00, 1, 8'd2,  8'd0,  0,  0,  8'h00, 1, 0, 0);
    v("z_s1",          1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h00, 1, 0, 0);
    v("z_s2_done",     1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h00, 0, 1, 0);
    v("z_idle",        1,  0,  0,  8'h00, 8'h00, 0, 8'd0,  8'd0,  0,  0,  8'h00, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      nRst   = vq[i].rst_n;
      WEN    = vq[i].wen;
      Sel    = vq[i].sel;
      Din    = {vq[i].s1, vq[i].s0};
      Start  = vq[i].start;
      Len    = vq[i].len;
      Stride = vq[i].stride;
      Dir    = vq[i].dir;
      Hold   = vq[i].hold;
      @(posedge Clk);
      #1;
      chk({vq[i].name, ".dout"}, 32'(dout), 32'(vq[i].e_dout));
      chk({vq[i].name, ".busy"}, 32'(Busy), 32'(vq[i].e_busy));
      chk({vq[i].name, ".done"}, 32'(Done), 32'(vq[i].e_done));
      chk({vq[i].name, ".wrap"}, 32'(Wrap), 32'(vq[i].e_wrap));
    end

    // Longer burst watched with a bounded wait: 0 + 6*3 = 0x12, Busy for 6 cycles.
    WEN = 1'b0; Hold = 1'b0; nRst = 1'b1;
    Start = 1'b1; Len = 8'd6; Stride = 8'd3; Dir = 1'b0;
    busy_cnt = 0; edges = 0; done_seen = 1'b0;
    while (!done_seen && edges < 20) begin
      @(posedge Clk);
      #1;
      Start = 1'b0;
      edges++;
      if (Busy) busy_cnt++;
      if (Done) done_seen = 1'b1;
    end
    chk("long.done_seen", 32'(done_seen), 32'd1);
    chk("long.edges", 32'(edges), 32'd7);
    chk("long.busy_cycles", 32'(busy_cnt), 32'd6);
    chk("long.dout", 32'(dout), 32'h12);
    @(posedge Clk);
    #1;
    chk("long.done_pulse_end", 32'(Done), 32'd0);
    chk("long.idle_busy", 32'(Busy), 32'd0);
    chk("long.dout_held", 32'(dout), 32'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
